// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/FIFO write-side bundle for fifo_wr_arbiter
// master: arbiter view; slave: producers plus FIFO write pins.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int MEMORY_WIDTH = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*MEMORY_WIDTH-1:0] wdata_in;
  logic [NUM_REQ-1:0]              gnt;
  logic [IDX_W-1:0]                gnt_idx;
  logic                            fifo_full;
  logic                            fifo_w_en;
  logic [MEMORY_WIDTH-1:0]         fifo_wdata;

  modport master (
    input  req, wdata_in, fifo_full,
    output gnt, gnt_idx, fifo_w_en, fifo_wdata
  );

  modport slave (
    output req, wdata_in, fifo_full,
    input  gnt, gnt_idx, fifo_w_en, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ producers
// Optional FIFO_ARB_BURST_EN: owner keeps the port for up to MAX_BURST consecutive words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MEMORY_WIDTH = 4,
  parameter int MAX_BURST    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_wr_arbiter_if.master     bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
  end

  logic [IDX_W-1:0]        last;
  logic [IDX_W-1:0]        rr_win;
  logic [IDX_W-1:0]        winner;
  logic                    w_en;
  logic [NUM_REQ-1:0]      gnt_vec;
  logic [MEMORY_WIDTH-1:0] sel_data;

  // The write strobe itself gates the grant, so reset and full both kill it combinationally.
  assign w_en = (|bus.req) & ~bus.fifo_full & ~rst;

  // Search from last+1, wrapping; last is visited at the end so it has lowest priority.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found  = 1'b0;
    cand   = '0;
    rr_win = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        rr_win = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  logic [CNT_W-1:0] burst_cnt;
  logic             keep;

  // burst_cnt == 0 only right after reset, where no owner exists yet.
  assign keep   = bus.req[last] && (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST));
  assign winner = keep ? last : rr_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (w_en) begin
      burst_cnt <= keep ? burst_cnt + CNT_W'(1) : CNT_W'(1);
    end
  end
`else
  assign winner = rr_win;
`endif

  always_comb begin
    gnt_vec  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_en && winner == IDX_W'(i)) begin
        gnt_vec[i] = 1'b1;
        sel_data   = bus.wdata_in[i*MEMORY_WIDTH +: MEMORY_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= IDX_W'(NUM_REQ - 1);
    end else if (w_en) begin
      last <= winner;
    end
  end

  assign bus.fifo_w_en  = w_en;
  assign bus.gnt        = gnt_vec;
  assign bus.gnt_idx    = w_en ? winner : '0;
  assign bus.fifo_wdata = sel_data;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
// Producer i presents data i+1; burst cases compile only with FIFO_ARB_BURST_EN.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int MW = 4;
  localparam int MB = 3;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .MEMORY_WIDTH(MW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .MEMORY_WIDTH(MW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, check the combinational result mid-cycle, then advance one edge.
  task automatic cyc(input string tag, input logic [3:0] r, input logic f,
                     input logic [3:0] exp_gnt, input logic [3:0] exp_data);
    logic [1:0] exp_idx;
    exp_idx = 2'd0;
    for (int i = 0; i < NR; i++) if (exp_gnt[i]) exp_idx = 2'(i);
    bus.req       = r;
    bus.fifo_full = f;
    #2;
    chk({tag, ".gnt"},   16'(bus.gnt),        16'(exp_gnt));
    chk({tag, ".wen"},   16'(bus.fifo_w_en),  16'(|exp_gnt));
    chk({tag, ".wdata"}, 16'(bus.fifo_wdata), 16'(exp_data));
    chk({tag, ".idx"},   16'(bus.gnt_idx),    16'(exp_idx));
    tick();
  endtask

  initial begin
    logic [3:0] rr_gnt [5];
    logic [3:0] rr_dat [5];
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_dat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    n_chk  = 0;
    n_pass = 0;

    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.fifo_full = 1'b0;
    bus.wdata_in  = 16'h4321;
    #2;
    chk("rst.gnt",   16'(bus.gnt),        16'h0);
    chk("rst.wen",   16'(bus.fifo_w_en),  16'h0);
    chk("rst.wdata", 16'(bus.fifo_wdata), 16'h0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) cyc($sformatf("rr%0d", i), 4'b1111, 1'b0, rr_gnt[i], rr_dat[i]);

    cyc("pre_full", 4'b1111, 1'b0, 4'b0010, 4'd2);
    for (int i = 0; i < 3; i++) cyc($sformatf("full%0d", i), 4'b1111, 1'b1, 4'b0000, 4'd0);
    cyc("post_full", 4'b1111, 1'b0, 4'b0100, 4'd3);

    for (int i = 0; i < 3; i++) cyc($sformatf("solo%0d", i), 4'b0100, 1'b0, 4'b0100, 4'd3);
    cyc("idle", 4'b0000, 1'b0, 4'b0000, 4'd0);

    // last = 2 here, so producer 3 is next; then reset mid-cycle.
    bus.req = 4'b1111;
    #2;
    chk("mid.gnt_before", 16'(bus.gnt), 16'h8);
    rst = 1'b1;
    #1;
    chk("mid.gnt_rst",   16'(bus.gnt),        16'h0);
    chk("mid.wen_rst",   16'(bus.fifo_w_en),  16'h0);
    chk("mid.wdata_rst", 16'(bus.fifo_wdata), 16'h0);
    tick();
    rst = 1'b0;
    cyc("mid.after", 4'b1111, 1'b0, 4'b0001, 4'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;

`ifdef FIFO_ARB_BURST_EN
    for (int i = 0; i < 3; i++) cyc($sformatf("b0_%0d", i), 4'b0011, 1'b0, 4'b0001, 4'd1);
    for (int i = 0; i < 3; i++) cyc($sformatf("b1_%0d", i), 4'b0011, 1'b0, 4'b0010, 4'd2);
    cyc("b0_again", 4'b0011, 1'b0, 4'b0001, 4'd1);
    cyc("b0_word2", 4'b0011, 1'b0, 4'b0001, 4'd1);
    cyc("drop0",    4'b0010, 1'b0, 4'b0010, 4'd2);
    cyc("b2_word1", 4'b0100, 1'b0, 4'b0100, 4'd3);
    bus.req = 4'b0100;
    #2;
    chk("b2_word2.gnt", 16'(bus.gnt), 16'h4);
    rst = 1'b1;
    #1;
    chk("b2_rst.gnt",   16'(bus.gnt),        16'h0);
    chk("b2_rst.wdata", 16'(bus.fifo_wdata), 16'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("brst0_%0d", i), 4'b0101, 1'b0, 4'b0001, 4'd1);
    cyc("brst_hand", 4'b0101, 1'b0, 4'b0100, 4'd3);
`else
    cyc("nb0", 4'b0011, 1'b0, 4'b0001, 4'd1);
    cyc("nb1", 4'b0011, 1'b0, 4'b0010, 4'd2);
    cyc("nb2", 4'b0011, 1'b0, 4'b0001, 4'd1);
    cyc("nb3", 4'b0011, 1'b0, 4'b0010, 4'd2);
    cyc("nb4", 4'b1101, 1'b0, 4'b0100, 4'd3);
    cyc("nb5", 4'b1101, 1'b0, 4'b1000, 4'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one synchronous FIFO (`fifo_synch`) between `NUM_REQ` producers. Each cycle it selects at most one requesting producer, drives that producer's data and a write strobe into the FIFO, and returns a one-hot grant so the producer advances. It sits directly in front of the FIFO's `w_en`/`wdata`/`full` pins; the read side of the FIFO is untouched.

## Interface
- `NUM_REQ`, 4: number of producers, at least 2.
- `MEMORY_WIDTH`, 4: data width; must equal the FIFO's `MEMORY_WIDTH`.
- `MAX_BURST`, 4: maximum consecutive words per owner when bursting is compiled in; at least 1.
- `IDX_W` (localparam): `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-producer write request; held high while that producer has a word.
- `wdata_in`  in  NUM_REQ*MEMORY_WIDTH  packed producer data; producer i occupies bits `[i*MEMORY_WIDTH +: MEMORY_WIDTH]`.
- `gnt`  out  NUM_REQ  one-hot grant; the producer's word is consumed at the next rising edge.
- `gnt_idx`  out  IDX_W  index of the granted producer; 0 when `fifo_w_en` = 0.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_w_en`  out  1  FIFO write enable.
- `fifo_wdata`  out  MEMORY_WIDTH  FIFO write data.

## Operation
- Combinational grant path, with state registers only:
  - `last`: IDX_W bits, index of the last producer that wrote.
  - `burst_cnt`: `$clog2(MAX_BURST+1)` bits. Present only with bursting.
- Write condition: `fifo_w_en = |req & ~fifo_full & ~rst`. `gnt` equals the one-hot of the winner when `fifo_w_en` is 1, and is 0 otherwise.
- Winner selection: the first requester found when searching from index `last+1`, wrapping modulo `NUM_REQ`. `last` itself has the lowest priority.
- When `fifo_w_en` is 0:
  - `fifo_wdata` is 0.
  - `last` and `burst_cnt` hold.
- On every edge where `fifo_w_en` is 1:
  - `last` is set to the winner index.
  - `fifo_wdata` equals the winner's `wdata_in` slice for the whole cycle.
- While `fifo_full` is 1:
  - No grant is issued and no state changes.
  - The same producer wins once `fifo_full` falls.
- A producer that drops `req` before being granted loses nothing. There is no queueing.
- Reset values, applied immediately and asynchronously:
  - `last` = `NUM_REQ-1`, so producer 0 has first priority.
  - `burst_cnt` = 0.
  - All outputs are forced to 0 while `rst` is high, regardless of `req`.

## Timing
- Zero-cycle latency: `req` high with `fifo_full` low gives `gnt` and `fifo_w_en` in the same cycle. The FIFO and the producer both act on the following rising edge.
- Throughput: one word per cycle whenever any `req` is high and the FIFO is not full. There are no bubbles on owner change.
- Single active requester: it is granted every cycle.
- `fifo_full` is used as presented. The FIFO must not assert a write while full; this block guarantees `fifo_w_en` = 0 whenever `fifo_full` = 1.
- Reset mid-operation:
  - Outputs drop in the same cycle that `rst` rises.
  - The first grant after release goes to the lowest-index requester.

## Configuration
- `FIFO_ARB_BURST_EN` defined: the current owner keeps the grant while all of the following hold:
  - its `req` is high;
  - `burst_cnt < MAX_BURST`;
  - the FIFO is not full.
- Burst counter rules with `FIFO_ARB_BURST_EN` defined:
  - `burst_cnt` increments on each write by the owner.
  - When the owner reaches `MAX_BURST` words or drops `req`, the winner is chosen by normal round robin from `last+1`, and `burst_cnt` restarts at 1 for the new owner.
  - A full stall holds ownership and the count.
- `FIFO_ARB_BURST_EN` undefined: strict one-word round robin. `burst_cnt` is not instantiated.

## Test plan
All scenarios use `NUM_REQ`=4, `MEMORY_WIDTH`=4, and producer i data = i+1.
- Reset: `rst`=1 with `req`=1111:
  - During reset: `gnt`=0000, `fifo_w_en`=0, `fifo_wdata`=0.
  - On the first cycle after release: `gnt`=0001, `fifo_wdata`=1.
- No burst, `req`=1111, `fifo_full`=0: `gnt` sequence is 0001, 0010, 0100, 1000, 0001, one per cycle, with `fifo_wdata` 1, 2, 3, 4, 1.
- `fifo_full`=1 for 3 cycles after the grant to producer 1:
  - During the stall: `gnt`=0000 and `fifo_w_en`=0.
  - On the first cycle after `fifo_full` falls: `gnt`=0100.
- `req`=0100 only: `gnt`=0100 every cycle and `fifo_wdata`=3 continuously; `gnt_idx`=2.
- `FIFO_ARB_BURST_EN`, `MAX_BURST`=3, `req`=0011: `gnt` is 0001 for 3 cycles, then 0010 for 3 cycles, then 0001 again.
  - Dropping `req[0]` after 2 words hands over to producer 1 on the next cycle.
- `FIFO_ARB_BURST_EN`, `rst` pulsed during producer 2's second burst word:
  - Outputs are 0 that cycle.
  - After release the grant goes to producer 0, with `burst_cnt` restarting at 1.
